// File: rtl/sid_voice_mixer.sv
// ============================================================================
// Module   : sid_voice_mixer
// Purpose  : Converts three unsigned waveform samples to signed form, scales
//            each one by its envelope level and sums the products onto a
//            filter-input bus and a direct (bypass) bus. A single shift-add
//            multiplier is shared by the three voices, one envelope bit per
//            clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sid_voice_mixer #(
  parameter int WAVE_W = 12,
  parameter int ENV_W  = 8,
  parameter int SUM_W  = 22
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               ce_1m_i,
  input  logic [WAVE_W-1:0]  wave0_i,
  input  logic [WAVE_W-1:0]  wave1_i,
  input  logic [WAVE_W-1:0]  wave2_i,
  input  logic [ENV_W-1:0]   env0_i,
  input  logic [ENV_W-1:0]   env1_i,
  input  logic [ENV_W-1:0]   env2_i,
  input  logic [2:0]         filt_en_i,
  input  logic               voice3off_i,
  output logic [SUM_W-1:0]   filt_out_o,
  output logic [SUM_W-1:0]   direct_out_o,
  output logic               out_valid_o,
  output logic               busy_o,
  output logic               overrun_o
);

  localparam int PROD_W = WAVE_W + ENV_W;
  localparam int BIT_W  = (ENV_W > 1) ? $clog2(ENV_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ENV_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 voice_q, voice_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [WAVE_W-1:0]          wave0_q, wave1_q, wave2_q, wave0_d, wave1_d, wave2_d;
  logic [ENV_W-1:0]           env0_q, env1_q, env2_q, env0_d, env1_d, env2_d;
  logic [2:0]                 filt_en_q, filt_en_d;
  logic                       v3off_q, v3off_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic signed [SUM_W-1:0]    facc_q, facc_d, dacc_q, dacc_d;
  logic [SUM_W-1:0]           filt_out_q, filt_out_d, direct_out_q, direct_out_d;
  logic                       out_valid_q, out_valid_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;

  logic [WAVE_W-1:0]          sel_wave;
  logic [ENV_W-1:0]           sel_env;
  logic                       sel_routed;
  logic signed [WAVE_W-1:0]   sw;
  logic signed [PROD_W-1:0]   sw_ext;
  logic signed [PROD_W-1:0]   term;
  logic signed [SUM_W-1:0]    prod_ext;

  // Pick the latched operands of the voice currently in the multiplier.
  always_comb begin
    sel_wave   = wave2_q;
    sel_env    = env2_q;
    sel_routed = filt_en_q[2];
    case (voice_q)
      2'd0: begin
        sel_wave   = wave0_q;
        sel_env    = env0_q;
        sel_routed = filt_en_q[0];
      end
      2'd1: begin
        sel_wave   = wave1_q;
        sel_env    = env1_q;
        sel_routed = filt_en_q[1];
      end
      default: ;
    endcase
  end

  // Offset-binary to two's complement (flip the MSB), then one partial product.
  assign sw       = {~sel_wave[WAVE_W-1], sel_wave[WAVE_W-2:0]};
  assign sw_ext   = {{ENV_W{sw[WAVE_W-1]}}, sw};
  assign term     = sel_env[bit_q] ? (sw_ext <<< bit_q) : '0;
  assign prod_ext = {{(SUM_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

  // Sequencer: next state plus all datapath next values.
  always_comb begin
    state_d      = state_q;
    voice_d      = voice_q;
    bit_d        = bit_q;
    wave0_d      = wave0_q;
    wave1_d      = wave1_q;
    wave2_d      = wave2_q;
    env0_d       = env0_q;
    env1_d       = env1_q;
    env2_d       = env2_q;
    filt_en_d    = filt_en_q;
    v3off_d      = v3off_q;
    prod_d       = prod_q;
    facc_d       = facc_q;
    dacc_d       = dacc_q;
    filt_out_d   = filt_out_q;
    direct_out_d = direct_out_q;
    out_valid_d  = 1'b0;
    busy_d       = busy_q;
    // A strobe in any non-idle state (including DONE) is dropped and flagged.
    overrun_d    = overrun_q | (ce_1m_i & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (ce_1m_i) begin
          wave0_d   = wave0_i;
          wave1_d   = wave1_i;
          wave2_d   = wave2_i;
          env0_d    = env0_i;
          env1_d    = env1_i;
          env2_d    = env2_i;
          filt_en_d = filt_en_i;
          v3off_d   = voice3off_i;
          facc_d    = '0;
          dacc_d    = '0;
          prod_d    = '0;
          voice_d   = 2'd0;
          bit_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        // Bit 0 starts a fresh product for this voice.
        prod_d = ((bit_q == '0) ? '0 : prod_q) + term;
        if (bit_q == LAST_BIT) begin
          state_d = S_ACC;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_ACC: begin
        if (sel_routed) begin
          facc_d = facc_q + prod_ext;
        end else if (!((voice_q == 2'd2) && v3off_q)) begin
          dacc_d = dacc_q + prod_ext;
        end
        bit_d = '0;
        if (voice_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          voice_d = voice_q + 2'd1;
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        filt_out_d   = facc_q;
        direct_out_d = dacc_q;
        out_valid_d  = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      voice_q      <= '0;
      bit_q        <= '0;
      wave0_q      <= '0;
      wave1_q      <= '0;
      wave2_q      <= '0;
      env0_q       <= '0;
      env1_q       <= '0;
      env2_q       <= '0;
      filt_en_q    <= '0;
      v3off_q      <= 1'b0;
      prod_q       <= '0;
      facc_q       <= '0;
      dacc_q       <= '0;
      filt_out_q   <= '0;
      direct_out_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      voice_q      <= voice_d;
      bit_q        <= bit_d;
      wave0_q      <= wave0_d;
      wave1_q      <= wave1_d;
      wave2_q      <= wave2_d;
      env0_q       <= env0_d;
      env1_q       <= env1_d;
      env2_q       <= env2_d;
      filt_en_q    <= filt_en_d;
      v3off_q      <= v3off_d;
      prod_q       <= prod_d;
      facc_q       <= facc_d;
      dacc_q       <= dacc_d;
      filt_out_q   <= filt_out_d;
      direct_out_q <= direct_out_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign filt_out_o   = filt_out_q;
  assign direct_out_o = direct_out_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sid_voice_mixer.sv
// ============================================================================
// Module   : tb_sid_voice_mixer
// Purpose  : Directed and randomised self-checking bench for sid_voice_mixer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sid_voice_mixer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ce = 1'b0;
  logic [11:0]        w0 = '0, w1 = '0, w2 = '0;
  logic [7:0]         e0 = '0, e1 = '0, e2 = '0;
  logic [2:0]         fen = '0;
  logic               v3off = 1'b0;
  logic signed [21:0] filt_out, direct_out;
  logic               out_valid, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  sid_voice_mixer #(.WAVE_W(12), .ENV_W(8), .SUM_W(22)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .ce_1m_i      (ce),
    .wave0_i      (w0),
    .wave1_i      (w1),
    .wave2_i      (w2),
    .env0_i       (e0),
    .env1_i       (e1),
    .env2_i       (e2),
    .filt_en_i    (fen),
    .voice3off_i  (v3off),
    .filt_out_o   (filt_out),
    .direct_out_o (direct_out),
    .out_valid_o  (out_valid),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  // Pulse ce for one edge (E0) and count edges until out_valid; lat = 28 expected.
  task automatic do_sample(output int lat, output bit timed_out);
    @(posedge clk); #1;
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
    lat = 0;
    timed_out = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic set_in(input logic [11:0] a0, a1, a2, input logic [7:0] b0, b1, b2,
                        input logic [2:0] f, input logic v);
    w0 = a0; w1 = a1; w2 = a2; e0 = b0; e1 = b1; e2 = b2; fen = f; v3off = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({filt_out, direct_out, out_valid, busy, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got f=%0d d=%0d v=%b b=%b o=%b, need all 0",
               filt_out, direct_out, out_valid, busy, overrun);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_voice();
    int lat; bit to;
    set_in(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'h00, 8'h00, 3'b000, 1'b0);
    do_sample(lat, to);
    n_checks++;
    if (to || lat !== 28) begin
      n_fail++;
      $display("FAIL latency: got %0d (timeout=%0b), need 28", lat, to);
    end
    n_checks++;
    if (int'(direct_out) !== 521985) begin
      n_fail++;
      $display("FAIL single_direct: got %0d, need 521985", direct_out);
    end
    n_checks++;
    if (int'(filt_out) !== 0) begin
      n_fail++;
      $display("FAIL single_filt: got %0d, need 0", filt_out);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_at_valid: got %b, need 0", busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || int'(direct_out) !== 521985) begin
      n_fail++;
      $display("FAIL pulse_hold: got v=%b d=%0d, need v=0 d=521985", out_valid, direct_out);
    end
  endtask

  task automatic test_busy();
    @(posedge clk); #1;
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_active: got %b, need 1", busy);
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_filter_all();
    int lat; bit to;
    set_in(12'h000, 12'h000, 12'h000, 8'hFF, 8'hFF, 8'hFF, 3'b111, 1'b0);
    do_sample(lat, to);
    n_checks++;
    if (to || int'(filt_out) !== -1566720 || int'(direct_out) !== 0) begin
      n_fail++;
      $display("FAIL filter_all: got f=%0d d=%0d to=%0b, need f=-1566720 d=0", filt_out, direct_out, to);
    end
  endtask

  task automatic test_direct_all();
    int lat; bit to;
    set_in(12'hFFF, 12'hFFF, 12'hFFF, 8'hFF, 8'hFF, 8'hFF, 3'b000, 1'b0);
    do_sample(lat, to);
    n_checks++;
    if (to || int'(direct_out) !== 1565955 || int'(filt_out) !== 0) begin
      n_fail++;
      $display("FAIL direct_all: got d=%0d f=%0d to=%0b, need d=1565955 f=0", direct_out, filt_out, to);
    end
    v3off = 1'b1;
    do_sample(lat, to);
    n_checks++;
    if (to || int'(direct_out) !== 1043970) begin
      n_fail++;
      $display("FAIL direct_v3off: got %0d to=%0b, need 1043970", direct_out, to);
    end
  endtask

  task automatic test_v3off_filter();
    int lat; bit to;
    set_in(12'h800, 12'h800, 12'hC00, 8'h00, 8'h00, 8'h80, 3'b100, 1'b1);
    do_sample(lat, to);
    n_checks++;
    if (to || int'(filt_out) !== 131072 || int'(direct_out) !== 0) begin
      n_fail++;
      $display("FAIL v3off_filter: got f=%0d d=%0d to=%0b, need f=131072 d=0", filt_out, direct_out, to);
    end
  endtask

  task automatic test_overrun();
    int cnt = 0;
    int lat = 0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b, need 0", overrun);
    end
    // wave 0x000 * env 1 on voice 1 direct = -2048
    set_in(12'h800, 12'h000, 12'h800, 8'h00, 8'h01, 8'h00, 3'b000, 1'b0);
    @(posedge clk); #1;
    ce = 1'b1;
    @(posedge clk); #1;
    // Inputs changed after E0 must not matter.
    set_in(12'hFFF, 12'hFFF, 12'hFFF, 8'hFF, 8'hFF, 8'hFF, 3'b111, 1'b1);
    for (int n = 1; n <= 45; n++) begin
      ce = (n == 10);
      @(posedge clk); #1;
      if (out_valid) begin
        cnt++;
        lat = n;
      end
    end
    ce = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b, need 1", overrun);
    end
    n_checks++;
    if (cnt !== 1 || lat !== 28) begin
      n_fail++;
      $display("FAIL overrun_pulses: got count=%0d lat=%0d, need count=1 lat=28", cnt, lat);
    end
    n_checks++;
    if (int'(direct_out) !== -2048 || int'(filt_out) !== 0) begin
      n_fail++;
      $display("FAIL overrun_result: got d=%0d f=%0d, need d=-2048 f=0", direct_out, filt_out);
    end
  endtask

  task automatic test_reset_abort();
    int cnt = 0;
    int lat; bit to;
    // Outputs are nonzero from the previous test; start a sample then reset at MUL(1,3).
    set_in(12'hFFF, 12'hFFF, 12'hFFF, 8'hFF, 8'hFF, 8'hFF, 3'b001, 1'b0);
    @(posedge clk); #1;
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({filt_out, direct_out, out_valid, busy, overrun} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got f=%0d d=%0d v=%b b=%b o=%b, need all 0",
               filt_out, direct_out, out_valid, busy, overrun);
    end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    n_checks++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL abort_no_valid: got %0d pulses, need 0", cnt);
    end
    do_sample(lat, to);
    n_checks++;
    if (to || int'(filt_out) !== 521985 || int'(direct_out) !== 1043970) begin
      n_fail++;
      $display("FAIL after_abort: got f=%0d d=%0d to=%0b, need f=521985 d=1043970", filt_out, direct_out, to);
    end
  endtask

  function automatic int prod_m(input int w, input int e);
    return (w - 2048) * e;
  endfunction

  task automatic test_random();
    int lat; bit to;
    int wv[3], ev[3], p;
    int exp_f, exp_d;
    logic [2:0] f;
    logic v;
    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < 3; j++) begin
        wv[j] = $urandom_range(0, 4095);
        ev[j] = $urandom_range(0, 255);
      end
      if (t == 0) begin wv[0] = 0; ev[0] = 255; wv[1] = 2048; ev[1] = 77; ev[2] = 0; end
      f = 3'($urandom_range(0, 7));
      v = 1'($urandom_range(0, 1));
      exp_f = 0;
      exp_d = 0;
      for (int j = 0; j < 3; j++) begin
        p = prod_m(wv[j], ev[j]);
        if (f[j]) exp_f += p;
        else if (!(j == 2 && v)) exp_d += p;
      end
      set_in(12'(wv[0]), 12'(wv[1]), 12'(wv[2]), 8'(ev[0]), 8'(ev[1]), 8'(ev[2]), f, v);
      do_sample(lat, to);
      n_checks++;
      if (to || int'(filt_out) !== exp_f || int'(direct_out) !== exp_d) begin
        n_fail++;
        $display("FAIL random_%0d: got f=%0d d=%0d to=%0b, need f=%0d d=%0d",
                 t, filt_out, direct_out, to, exp_f, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_voice();
    test_busy();
    test_filter_all();
    test_direct_all();
    test_v3off_filter();
    test_overrun();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
